// File: rtl/ov5640_sccb_pkg.sv
// Shared types and constants for the OV5640 SCCB write master.
package ov5640_sccb_pkg;

   typedef enum logic [2:0] {IDLE, START, BIT, STOP, GAP} state_t;

   localparam int         FRAME_BITS   = 36;
   localparam int         START_Q      = 2;
   localparam int         STOP_Q       = 3;
   localparam logic [7:0] DEF_DEV_ADDR = 8'h78;

   // Ack slots hold 1 so that driving ~bit releases SIOD there.
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0]  dev,
                                                         input logic [15:0] addr,
                                                         input logic [7:0]  value);
      return {dev, 1'b1, addr[15:8], 1'b1, addr[7:0], 1'b1, value, 1'b1};
   endfunction

   function automatic logic is_ack_slot(input logic [5:0] idx);
      return (idx % 6'd9) == 6'd8;
   endfunction

endpackage

// File: rtl/ov5640_sccb_qtick_gen.sv
// Quarter-SCL-period strobe generator; counts only while enabled, restarts on clear.
module sccb_qtick_gen #(
   parameter int Q = 125
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   output logic qtick
);

   localparam int            CW   = (Q > 1) ? $clog2(Q) : 1;
   localparam logic [CW-1:0] LAST = CW'(Q - 1);

   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

   assign qtick = en && (cnt == LAST);

endmodule

// File: rtl/ov5640_sccb_master.sv
// SCCB write master: one accepted start becomes a START / 36-bit frame / STOP / bus-free gap sequence.
module ov5640_sccb_master
   import ov5640_sccb_pkg::*;
#(
   parameter int         CLK_HZ   = 50_000_000,
   parameter int         SCL_HZ   = 100_000,
   parameter logic [7:0] DEV_ADDR = DEF_DEV_ADDR,
   parameter int         GAP_Q    = 4
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] address,
   input  logic [7:0]  data,
   output logic        ready,
   output logic        done,
   output logic        nack,
   output logic        sioc,
   output logic        siod_oe,
   input  logic        siod_in
);

   localparam int         Q        = CLK_HZ / (4 * SCL_HZ);
   localparam int         QW       = (GAP_Q > 4) ? $clog2(GAP_Q) : 2;
   localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

   if (Q < 1) begin : g_bad_clk
      $error("CLK_HZ/(4*SCL_HZ) must be at least 1");
   end
   if (GAP_Q < 1) begin : g_bad_gap
      $error("GAP_Q must be at least 1");
   end

   state_t                 state;
   logic [QW-1:0]          quarter;
   logic [5:0]             bit_idx;
   logic [FRAME_BITS-1:0]  shreg;
   logic                   qtick;
   logic                   accept;

   assign accept = (state == IDLE) && start;
   assign ready  = (state == IDLE) && !start;

   sccb_qtick_gen #(.Q(Q)) u_qtick (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .en      (state != IDLE),
      .clr     (accept),
      .qtick   (qtick)
   );

   // Each qtick closes the current quarter; outputs for the next quarter are set on that edge.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         quarter <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         sioc    <= 1'b1;
         siod_oe <= 1'b0;
         done    <= 1'b0;
         nack    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shreg   <= build_frame(DEV_ADDR, address, data);
                  nack    <= 1'b0;
                  quarter <= '0;
                  bit_idx <= '0;
                  sioc    <= 1'b1;
                  siod_oe <= 1'b1;
                  state   <= START;
               end
            end
            START: begin
               if (qtick) begin
                  if (quarter == QW'(START_Q - 1)) begin
                     quarter <= '0;
                     siod_oe <= ~shreg[FRAME_BITS-1];
                     state   <= BIT;
                  end else begin
                     quarter <= quarter + 1'b1;
                     sioc    <= 1'b0;
                  end
               end
            end
            BIT: begin
               if (qtick) begin
                  quarter <= quarter + 1'b1;
                  case (quarter[1:0])
                     2'd0: sioc <= 1'b1;
                     2'd1: sioc <= 1'b1;
                     2'd2: begin
                        sioc <= 1'b0;
                        if (is_ack_slot(bit_idx))
                           nack <= nack | siod_in;
                     end
                     default: begin
                        quarter <= '0;
                        if (bit_idx == LAST_BIT) begin
                           siod_oe <= 1'b1;
                           state   <= STOP;
                        end else begin
                           bit_idx <= bit_idx + 1'b1;
                           shreg   <= {shreg[FRAME_BITS-2:0], 1'b1};
                           siod_oe <= ~shreg[FRAME_BITS-2];
                        end
                     end
                  endcase
               end
            end
            STOP: begin
               if (qtick) begin
                  if (quarter == QW'(STOP_Q - 1)) begin
                     quarter <= '0;
                     state   <= GAP;
                  end else begin
                     quarter <= quarter + 1'b1;
                     if (quarter == '0)
                        sioc <= 1'b1;
                     else
                        siod_oe <= 1'b0;
                  end
               end
            end
            GAP: begin
               if (qtick) begin
                  if (quarter == QW'(GAP_Q - 1)) begin
                     quarter <= '0;
                     done    <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     quarter <= quarter + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ov5640_sccb_master.sv
// Self-checking bench: bus monitor decodes SIOC/SIOD frames and compares them to a byte-level frame model.
module tb_ov5640_sccb_master;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        start, start_s;
   logic [15:0] address;
   logic [7:0]  data;
   logic        ready, done, nack, sioc, siod_oe, siod_in;
   logic        ready_s, done_s, nack_s, sioc_s, siod_oe_s, siod_in_s;
   logic [3:0]  nack_mask;
   logic        slave_rel;
   logic        last_nack;

   always #5 clk_sys = ~clk_sys;

   ov5640_sccb_master #(.CLK_HZ(400_000), .SCL_HZ(100_000), .DEV_ADDR(8'h78), .GAP_Q(4)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .address(address), .data(data),
      .ready(ready), .done(done), .nack(nack), .sioc(sioc), .siod_oe(siod_oe), .siod_in(siod_in)
   );

   ov5640_sccb_master #(.CLK_HZ(50_000_000), .SCL_HZ(100_000), .DEV_ADDR(8'h78), .GAP_Q(4)) dut_slow (
      .clk_sys(clk_sys), .reset_n(reset_n), .start(start_s), .address(address), .data(data),
      .ready(ready_s), .done(done_s), .nack(nack_s), .sioc(sioc_s), .siod_oe(siod_oe_s), .siod_in(siod_in_s)
   );

   assign siod_in_s = 1'b0;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   // Expected pull-low pattern seen at each SIOC rise: ~bit for data, released in ack slots.
   function automatic logic [35:0] exp_pull(input logic [15:0] a, input logic [7:0] d);
      logic [7:0]  bytes [4];
      logic [35:0] v;
      v = '0;
      bytes[0] = 8'h78; bytes[1] = a[15:8]; bytes[2] = a[7:0]; bytes[3] = d;
      for (int i = 0; i < 4; i++) begin
         for (int b = 7; b >= 0; b--) v = {v[34:0], ~bytes[i][b]};
         v = {v[34:0], 1'b0};
      end
      return v;
   endfunction

   // Bus monitor: START/STOP from the master's drive, one bit per SIOC rise.
   int          mon_cnt = 0;
   logic [35:0] mon_frame = '0;
   logic [35:0] frames [$];
   int          start_cnt = 0, stop_cnt = 0, done_cnt = 0;
   logic        prev_sioc = 1'b1, prev_line = 1'b1;

   always begin
      @(posedge clk_sys);
      #1;
      if (!reset_n) begin
         mon_cnt   = 0;
         mon_frame = '0;
      end else if (sioc && prev_sioc && prev_line && siod_oe) begin
         start_cnt++;
         mon_cnt   = 0;
         mon_frame = '0;
      end else if (sioc && !prev_sioc) begin
         if (mon_cnt < 36) mon_frame = {mon_frame[34:0], siod_oe};
         mon_cnt++;
      end else if (sioc && prev_sioc && !prev_line && !siod_oe) begin
         stop_cnt++;
         // 36 data rises plus the rise that sets up the STOP condition.
         if (mon_cnt == 37) frames.push_back(mon_frame);
      end
      if (reset_n && done) done_cnt++;
      prev_sioc = sioc;
      prev_line = ~siod_oe;
   end

   // Slave: acks every slot unless its bit in nack_mask asks for a NACK.
   always_comb begin
      slave_rel = 1'b1;
      if (mon_cnt >= 1 && mon_cnt <= 36 && ((mon_cnt - 1) % 9) == 8)
         slave_rel = nack_mask[2'((mon_cnt - 1) / 9)];
   end
   assign siod_in = siod_oe ? 1'b0 : slave_rel;

   task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic [3:0] mask,
                           input logic exp_nack, input bit poke, input string tag);
      int busy = 0, starts0, stops0, dones0;
      bit got_done = 0, chk10 = 0, chk19 = 0, poke_pending = 0, poked = 0, ready_bad = 0;
      logic [35:0] fr;
      nack_mask = mask;
      starts0 = start_cnt; stops0 = stop_cnt; dones0 = done_cnt;
      @(posedge clk_sys); #1;
      start = 1'b1; address = a; data = d;
      @(negedge clk_sys);
      check({tag, " ready in start cycle"}, ready, 1'b0);
      check({tag, " nack held until start"}, nack, last_nack);
      while (!got_done && busy < 400) begin
         @(posedge clk_sys); #1;
         start = poke_pending;
         if (poke_pending) begin
            address = 16'h1234; data = 8'h55;
         end else begin
            address = 16'($urandom); data = 8'($urandom);
         end
         poke_pending = 0;
         @(negedge clk_sys);
         if (done) got_done = 1;
         else begin
            busy++;
            if (ready !== 1'b0) ready_bad = 1;
            if (busy == 1) check({tag, " nack cleared on accept"}, nack, 1'b0);
            if (!chk10 && mon_cnt == 10) begin
               chk10 = 1;
               check({tag, " nack after ack slot 0"}, nack, mask[0]);
            end
            if (!chk19 && mon_cnt == 19) begin
               chk19 = 1;
               check({tag, " nack after ack slot 1"}, nack, mask[1:0] != 2'b00);
            end
            if (poke && !poked && mon_cnt == 11) begin
               poked = 1;
               poke_pending = 1;
            end
         end
      end
      start = 1'b0;
      check({tag, " done seen"}, got_done, 1'b1);
      check({tag, " busy cycles"}, busy, 153);
      check({tag, " ready low while busy"}, ready_bad, 1'b0);
      check({tag, " ready in done cycle"}, ready, 1'b1);
      check({tag, " nack at done"}, nack, exp_nack);
      if (poke) check({tag, " busy start issued"}, poked, 1'b1);
      @(negedge clk_sys);
      check({tag, " done single pulse"}, done, 1'b0);
      check({tag, " done count"}, done_cnt - dones0, 1);
      check({tag, " start conditions"}, start_cnt - starts0, 1);
      check({tag, " stop conditions"}, stop_cnt - stops0, 1);
      check({tag, " frames captured"}, frames.size(), 1);
      if (frames.size() > 0) begin
         fr = frames.pop_front();
         check({tag, " frame bits"}, fr, exp_pull(a, d));
      end
      frames.delete();
      last_nack = exp_nack;
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      logic [3:0]  mask;
      logic        exp_nack;
   } vec_t;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   vec_t vecs [9];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      wr_t fifo [$];
      wr_t sent [$];
      wr_t w;
      int  cyc, reads, dones0, starts0, busy;
      int  rises [$];
      logic prev_s;
      bit  got;

      reset_n = 1'b0; start = 1'b0; start_s = 1'b0; address = '0; data = '0;
      nack_mask = '0; last_nack = 1'b0;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      check("reset sioc", sioc, 1'b1);
      check("reset siod_oe", siod_oe, 1'b0);
      check("reset done", done, 1'b0);
      check("reset nack", nack, 1'b0);
      check("reset ready", ready, 1'b1);
      @(posedge clk_sys); #1;
      reset_n = 1'b1;

      vecs[0] = '{16'h3008, 8'h82, 4'b0000, 1'b0};
      vecs[1] = '{16'h3008, 8'h82, 4'b0010, 1'b1};
      vecs[2] = '{16'h3103, 8'h11, 4'b0000, 1'b0};
      vecs[3] = '{16'hFFFF, 8'h00, 4'b1000, 1'b1};
      vecs[4] = '{16'h0000, 8'hFF, 4'b0001, 1'b1};
      for (int i = 5; i < 9; i++) begin
         vecs[i].addr     = 16'($urandom);
         vecs[i].data     = 8'($urandom);
         vecs[i].mask     = 4'($urandom_range(0, 15));
         vecs[i].exp_nack = (vecs[i].mask != 4'h0);
      end
      for (int i = 0; i < 9; i++)
         do_write(vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].exp_nack, 1'b0,
                  $sformatf("vec%0d", i));

      do_write(16'h3008, 8'h82, 4'b0000, 1'b0, 1'b1, "busy start");

      // Reset in the middle of bit 20.
      nack_mask = '0;
      @(posedge clk_sys); #1;
      start = 1'b1; address = 16'h3008; data = 8'h82;
      @(posedge clk_sys); #1;
      start = 1'b0;
      cyc = 0;
      while (mon_cnt != 21 && cyc < 400) begin
         @(negedge clk_sys);
         cyc++;
      end
      check("reached bit 20", mon_cnt, 21);
      reset_n = 1'b0;
      #1;
      check("mid reset sioc", sioc, 1'b1);
      check("mid reset siod_oe", siod_oe, 1'b0);
      check("mid reset ready", ready, 1'b1);
      check("mid reset done", done, 1'b0);
      @(posedge clk_sys); @(posedge clk_sys); #1;
      reset_n = 1'b1;
      frames.delete();
      last_nack = 1'b0;
      do_write(16'h4300, 8'h30, 4'b0000, 1'b0, 1'b0, "post reset");

      // Upstream FIFO: read when ready, start one cycle later.
      nack_mask = '0;
      fifo.push_back('{16'h3103, 8'h11});
      fifo.push_back('{16'h3008, 8'h82});
      fifo.push_back('{16'h3017, 8'hFF});
      reads = 0; dones0 = done_cnt; starts0 = start_cnt; cyc = 0;
      frames.delete();
      while ((fifo.size() > 0 || done_cnt - dones0 < 3) && cyc < 2000) begin
         @(negedge clk_sys);
         cyc++;
         if (ready && fifo.size() > 0) begin
            w = fifo.pop_front();
            reads++;
            sent.push_back(w);
            @(posedge clk_sys); #1;
            start = 1'b1; address = w.a; data = w.d;
            @(negedge clk_sys);
            cyc++;
            check("fifo ready low in start cycle", ready, 1'b0);
            @(posedge clk_sys); #1;
            start = 1'b0;
         end
      end
      @(negedge clk_sys);
      check("fifo reads", reads, 3);
      check("fifo dones", done_cnt - dones0, 3);
      check("fifo starts", start_cnt - starts0, 3);
      check("fifo frames", frames.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < frames.size() && i < sent.size())
            check($sformatf("fifo frame %0d", i), frames[i], exp_pull(sent[i].a, sent[i].d));
      frames.delete();

      // Real clock ratio: Q = 125.
      @(posedge clk_sys); #1;
      start_s = 1'b1; address = 16'h3008; data = 8'h82;
      @(posedge clk_sys); #1;
      start_s = 1'b0;
      busy = 0; got = 0; prev_s = 1'b1;
      while (!got && busy < 25000) begin
         @(negedge clk_sys);
         if (done_s) got = 1;
         else begin
            busy++;
            if (sioc_s && !prev_s) rises.push_back(busy);
            prev_s = sioc_s;
         end
      end
      check("slow done seen", got, 1'b1);
      check("slow busy cycles", busy, 19125);
      check("slow sioc rises", rises.size(), 37);
      if (rises.size() >= 3)
         check("slow sioc period", rises[2] - rises[1], 500);
      check("slow nack", nack_s, 1'b0);
      check("slow ready at done", ready_s, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
